sdram_client_arb: RTL and testbench
===================================

Name: sdram_client_arb

Overview:
- Shares one toggle-handshake SDRAM controller port among N_CLIENTS requesters, each using the same toggle req/ack protocol.
- Example use: 68k RAM, Z80 bus bridge and a cartridge mapper sharing the ROM/RAM port.
- Round-robin grant; one transaction outstanding downstream at a time.
- Latches the winning client's command and returns read data and ack to that client only.

Parameters:
- N_CLIENTS, 3, number of requesters (2..8)
- AW, 23, word address width (bits [AW:1])

Ports:
- clk  in  1  system clock (SDRAM clock domain)
- reset  in  1  asynchronous active-high reset
- c_req  in  N_CLIENTS  per-client toggle request; pending when c_req[i] != c_ack[i]
- c_ack  out  N_CLIENTS  per-client toggle acknowledge
- c_we  in  N_CLIENTS  1=write, 0=read
- c_a  in  N_CLIENTS*AW  client i word address in slice [i*AW +: AW]
- c_d  in  N_CLIENTS*16  write data, slice [i*16 +: 16]
- c_u_n  in  N_CLIENTS  upper byte mask, active low
- c_l_n  in  N_CLIENTS  lower byte mask, active low
- c_q  out  16  read data of last completed read (shared bus)
- c_qv  out  N_CLIENTS  one-cycle strobe: c_q valid for client i
- m_req  out  1  toggle request to SDRAM controller
- m_ack  in  1  toggle acknowledge from controller
- m_we  out  1  latched write flag
- m_a  out  AW  latched address
- m_d  out  16  latched write data
- m_u_n, m_l_n  out  1 each  latched byte masks
- m_q  in  16  controller read data, valid when m_ack toggles

Behaviour:
- Reset values: c_ack=0, c_qv=0, c_q=0, m_req=0, m_we=0, m_a=0, m_d=0, m_u_n=1, m_l_n=1. State IDLE, rr_ptr=0, owner=0.
- pending[i] = c_req[i] ^ c_ack[i], evaluated combinationally each cycle.
- State IDLE:
  - If any pending, pick the first pending index scanning rr_ptr, rr_ptr+1, … modulo N_CLIENTS.
  - Next edge: owner<=winner; latch m_we/m_a/m_d/m_u_n/m_l_n from the winner's slices; m_req<=~m_req; rr_ptr<=(winner+1) mod N_CLIENTS; go to BUSY.
  - Grant latency: 1 cycle from pending visible to m_req toggle.
- State BUSY:
  - m_* outputs are held stable; new requests only accumulate as pending.
  - When m_ack==m_req: c_ack[owner]<=c_req[owner].
  - If !m_we: c_q<=m_q and c_qv[owner]<=1 for exactly one cycle.
  - Go to IDLE.
  - Ack latency to client: 1 cycle after m_ack matches.
- Back-to-back: IDLE re-arbitrates on the cycle after completion. Minimum 2 cycles between consecutive m_req toggles.
- Simultaneous pending: resolved purely by rr_ptr. A client that just completed is scanned last.
- A client's req toggle arriving in the same cycle its ack is written is not lost. Pending is recomputed next cycle from the current c_req.
- Clients must not toggle req again before ack matches. A double toggle cancels its own pending state; this is undefined and not checked.
- c_we/c_a/c_d/masks need only be stable from the req toggle until ack; they are sampled once at grant.
- Reset mid-BUSY: returns to IDLE with m_req=0. The downstream controller is reset by the same reset, so no stale ack is expected.
- N_CLIENTS=1 degenerates to a registered pass-through with 1-cycle added latency each way.

Optional Feature:
- Macro SDRAM_ARB_PRIO0_EN.
- When defined: client 0 wins whenever pending in IDLE, regardless of rr_ptr. rr_ptr is not updated on a client-0 grant. Remaining clients stay round-robin among themselves.
- When undefined: pure round-robin as above.
- Client 0 is intended for latency-critical CPU fetch.

Test Plan:
- Reset then single read: client 1 toggles c_req[1] with a=0x000123 -> next cycle m_req=1, m_a=0x000123, m_we=0. Model acks after 5 cycles with m_q=0xBEEF -> c_ack[1]=1 and c_q=0xBEEF one cycle later; c_qv[1] pulses for 1 cycle.
- Write passthrough: client 2 writes d=0x5A5A, u_n=0, l_n=1 -> m_d=0x5A5A, m_u_n=0, m_l_n=1, m_we=1. c_ack[2] toggles after m_ack; c_qv stays 0.
- Fairness: all three clients pending continuously for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2; each client gets exactly 3.
- Hold while busy: client 0 toggles during client 1's BUSY -> m_a unchanged until client 1 acks. Client 0 granted on the cycle after return to IDLE.
- Reset mid-op: assert reset 2 cycles after grant -> all outputs at reset values immediately (async). After release with no pending requests, m_req stays 0.
- With SDRAM_ARB_PRIO0_EN: clients 0 and 2 pending, rr_ptr=2 -> client 0 granted first, then client 2. Without the macro -> client 2 first.

Source files
------------

// File: rtl/sdram_client_arb.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port among N_CLIENTS requesters.
// Optional macro SDRAM_ARB_PRIO0_EN: client 0 wins whenever pending; the others stay round-robin.
module sdram_client_arb #(
    parameter int unsigned N_CLIENTS = 3,
    parameter int unsigned AW        = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CLIENTS-1:0]    c_req,
    output logic [N_CLIENTS-1:0]    c_ack,
    input  logic [N_CLIENTS-1:0]    c_we,
    input  logic [N_CLIENTS*AW-1:0] c_a,
    input  logic [N_CLIENTS*16-1:0] c_d,
    input  logic [N_CLIENTS-1:0]    c_u_n,
    input  logic [N_CLIENTS-1:0]    c_l_n,
    output logic [15:0]             c_q,
    output logic [N_CLIENTS-1:0]    c_qv,
    output logic                    m_req,
    input  logic                    m_ack,
    output logic                    m_we,
    output logic [AW-1:0]           m_a,
    output logic [15:0]             m_d,
    output logic                    m_u_n,
    output logic                    m_l_n,
    input  logic [15:0]             m_q
);

    localparam int unsigned PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 r_state, w_state_nxt;
    logic [PW-1:0]          r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0]          r_owner, w_owner_nxt;
    logic [N_CLIENTS-1:0]   r_c_ack, w_c_ack_nxt;
    logic [N_CLIENTS-1:0]   r_c_qv, w_c_qv_nxt;
    logic [15:0]            r_c_q, w_c_q_nxt;
    logic                   r_m_req, w_m_req_nxt;
    logic                   r_m_we, w_m_we_nxt;
    logic [AW-1:0]          r_m_a, w_m_a_nxt;
    logic [15:0]            r_m_d, w_m_d_nxt;
    logic                   r_m_u_n, w_m_u_n_nxt;
    logic                   r_m_l_n, w_m_l_n_nxt;

    logic [N_CLIENTS-1:0]   w_pending;
    logic                   w_any;
    logic                   w_found;
    logic                   w_done;
    logic [PW-1:0]          w_scan;
    logic [PW-1:0]          w_winner;
    logic [PW-1:0]          w_next_ptr;

    // Winner selection: first pending index starting at rr_ptr, wrapping modulo N_CLIENTS.
    always_comb begin
        w_pending = c_req ^ r_c_ack;
        w_any     = |w_pending;
        w_found   = 1'b0;
        w_scan    = '0;
        w_winner  = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            w_scan = PW'((32'(r_rr_ptr) + k) % N_CLIENTS);
            if (!w_found && w_pending[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (w_pending[0]) begin
            w_winner = '0;
        end
`endif
        w_next_ptr = (32'(w_winner) == N_CLIENTS - 1) ? '0 : w_winner + PW'(1);
`ifdef SDRAM_ARB_PRIO0_EN
        // A client-0 grant leaves the rotation of the other clients untouched.
        if (w_winner == '0) begin
            w_next_ptr = r_rr_ptr;
        end
`endif
    end

    assign w_done = (m_ack == r_m_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_any)  w_state_nxt = StBusy;
            StBusy: if (w_done) w_state_nxt = StIdle;
            default:            w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_c_ack_nxt  = r_c_ack;
        w_c_qv_nxt   = '0;
        w_c_q_nxt    = r_c_q;
        w_m_req_nxt  = r_m_req;
        w_m_we_nxt   = r_m_we;
        w_m_a_nxt    = r_m_a;
        w_m_d_nxt    = r_m_d;
        w_m_u_n_nxt  = r_m_u_n;
        w_m_l_n_nxt  = r_m_l_n;
        if (r_state == StIdle && w_any) begin
            w_owner_nxt  = w_winner;
            w_m_we_nxt   = c_we[w_winner];
            w_m_a_nxt    = c_a[32'(w_winner) * AW +: AW];
            w_m_d_nxt    = c_d[32'(w_winner) * 16 +: 16];
            w_m_u_n_nxt  = c_u_n[w_winner];
            w_m_l_n_nxt  = c_l_n[w_winner];
            w_m_req_nxt  = ~r_m_req;
            w_rr_ptr_nxt = w_next_ptr;
        end else if (r_state == StBusy && w_done) begin
            w_c_ack_nxt[r_owner] = c_req[r_owner];
            if (!r_m_we) begin
                w_c_q_nxt           = m_q;
                w_c_qv_nxt[r_owner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_c_ack  <= '0;
            r_c_qv   <= '0;
            r_c_q    <= '0;
            r_m_req  <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_a    <= '0;
            r_m_d    <= '0;
            r_m_u_n  <= 1'b1;
            r_m_l_n  <= 1'b1;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_c_ack  <= w_c_ack_nxt;
            r_c_qv   <= w_c_qv_nxt;
            r_c_q    <= w_c_q_nxt;
            r_m_req  <= w_m_req_nxt;
            r_m_we   <= w_m_we_nxt;
            r_m_a    <= w_m_a_nxt;
            r_m_d    <= w_m_d_nxt;
            r_m_u_n  <= w_m_u_n_nxt;
            r_m_l_n  <= w_m_l_n_nxt;
        end
    end

    assign c_ack = r_c_ack;
    assign c_qv  = r_c_qv;
    assign c_q   = r_c_q;
    assign m_req = r_m_req;
    assign m_we  = r_m_we;
    assign m_a   = r_m_a;
    assign m_d   = r_m_d;
    assign m_u_n = r_m_u_n;
    assign m_l_n = r_m_l_n;

endmodule

// File: tb/tb_sdram_client_arb.sv
// Self-checking bench for sdram_client_arb with a toggle-handshake SDRAM controller model.
// Grant and read-data expectations are queued at issue time and popped as the DUT responds.
module tb_sdram_client_arb;

    localparam int N  = 3;
    localparam int AW = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      c_req, c_ack, c_we, c_u_n, c_l_n, c_qv;
    logic [N*AW-1:0]   c_a;
    logic [N*16-1:0]   c_d;
    logic [15:0]       c_q, m_d, m_q;
    logic              m_req, m_ack, m_we, m_u_n, m_l_n;
    logic [AW-1:0]     m_a;

    typedef struct {
        int          cl;
        logic        we;
        logic [AW-1:0] a;
        logic [15:0] d;
        logic        u_n;
        logic        l_n;
    } txn_t;

    typedef struct {
        int          cl;
        logic [15:0] q;
    } rd_t;

    txn_t exp_q[$];
    rd_t  rd_q[$];

    int   checks = 0;
    int   errors = 0;
    int   lat    = 5;
    logic last_mreq = 1'b0;

    sdram_client_arb #(.N_CLIENTS(N), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .c_req (c_req),
        .c_ack (c_ack),
        .c_we  (c_we),
        .c_a   (c_a),
        .c_d   (c_d),
        .c_u_n (c_u_n),
        .c_l_n (c_l_n),
        .c_q   (c_q),
        .c_qv  (c_qv),
        .m_req (m_req),
        .m_ack (m_ack),
        .m_we  (m_we),
        .m_a   (m_a),
        .m_d   (m_d),
        .m_u_n (m_u_n),
        .m_l_n (m_l_n),
        .m_q   (m_q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rdata_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hBFCC;
    endfunction

    // Controller model: acks `lat` cycles after seeing a new m_req toggle.
    initial begin
        int mcnt;
        bit mbusy;
        m_ack = 1'b0;
        m_q   = 16'h0;
        mbusy = 1'b0;
        mcnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ack = 1'b0;
                mbusy = 1'b0;
            end else if (mbusy) begin
                mcnt--;
                if (mcnt == 0) begin
                    m_q   = rdata_f(m_a);
                    m_ack = m_req;
                    mbusy = 1'b0;
                end
            end else if (m_req != m_ack) begin
                mbusy = 1'b1;
                mcnt  = lat;
            end
        end
    end

    task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic u_n, input logic l_n);
        txn_t t;
        c_we[i]           = we;
        c_a[i*AW +: AW]   = a;
        c_d[i*16 +: 16]   = d;
        c_u_n[i]          = u_n;
        c_l_n[i]          = l_n;
        c_req[i]          = ~c_req[i];
        t.cl = i; t.we = we; t.a = a; t.d = d; t.u_n = u_n; t.l_n = l_n;
        exp_q.push_back(t);
        if (!we) rd_q.push_back('{i, rdata_f(a)});
    endtask

    task automatic wait_mreq(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            if (m_req !== last_mreq) begin
                last_mreq = m_req;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int i, output int cyc, output logic [15:0] q,
                             output logic [N-1:0] qv, output int qv_cnt, output bit ok);
        ok = 1'b0; cyc = 0; q = '0; qv = '0; qv_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            if (c_qv !== '0) begin
                qv = c_qv;
                q  = c_q;
                qv_cnt++;
            end
            if (c_ack[i] === c_req[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        c_req = '0; c_we = '0; c_a = '0; c_d = '0; c_u_n = '1; c_l_n = '1;
        #1;
        checks++;
        if (c_ack !== 3'b000 || c_qv !== 3'b000 || c_q !== 16'h0) begin
            errors++;
            $display("FAIL reset_client: ack=%b qv=%b q=%h want 000 000 0000", c_ack, c_qv, c_q);
        end
        checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || m_a !== '0 || m_d !== 16'h0) begin
            errors++;
            $display("FAIL reset_mport: req=%b we=%b a=%h d=%h want 0 0 0 0", m_req, m_we, m_a, m_d);
        end
        checks++;
        if (m_u_n !== 1'b1 || m_l_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_masks: u_n=%b l_n=%b want 1 1", m_u_n, m_l_n);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_mreq: got %b want 0", m_req);
        end
    endtask

    task automatic test_single_read;
        txn_t t; rd_t r; int cyc; bit ok; logic [15:0] q; logic [N-1:0] qv; int qn;
        lat = 5;
        issue(1, 1'b0, 23'h000123, 16'h0, 1'b0, 1'b0);
        wait_mreq(cyc, ok);
        t = exp_q.pop_front();
        checks++;
        if (!ok || cyc != 1 || m_req !== 1'b1) begin
            errors++;
            $display("FAIL read_grant_latency: got %0d cycles req=%b want 1 cycle req=1", cyc, m_req);
        end
        checks++;
        if (m_a !== t.a || m_we !== 1'b0) begin
            errors++;
            $display("FAIL read_cmd: a=%h we=%b want a=%h we=0", m_a, m_we, t.a);
        end
        wait_done(1, cyc, q, qv, qn, ok);
        r = rd_q.pop_front();
        checks++;
        if (!ok || cyc != 6 || c_ack !== 3'b010) begin
            errors++;
            $display("FAIL read_ack: ok=%0d cyc=%0d ack=%b want cyc=6 ack=010", ok, cyc, c_ack);
        end
        checks++;
        if (q !== 16'hBEEF || q !== r.q || qv !== 3'b010 || qn != 1) begin
            errors++;
            $display("FAIL read_data: q=%h qv=%b n=%0d want BEEF 010 1", q, qv, qn);
        end
        @(negedge clk);
        checks++;
        if (c_qv !== 3'b000) begin
            errors++;
            $display("FAIL read_qv_pulse: got %b want 000", c_qv);
        end
    endtask

    task automatic test_write;
        txn_t t; int cyc; bit ok; logic [15:0] q; logic [N-1:0] qv; int qn;
        lat = 3;
        issue(2, 1'b1, 23'h0ABCDE, 16'h5A5A, 1'b0, 1'b1);
        wait_mreq(cyc, ok);
        t = exp_q.pop_front();
        checks++;
        if (!ok || m_we !== 1'b1 || m_a !== t.a || m_d !== 16'h5A5A) begin
            errors++;
            $display("FAIL write_cmd: we=%b a=%h d=%h want 1 %h 5a5a", m_we, m_a, m_d, t.a);
        end
        checks++;
        if (m_u_n !== 1'b0 || m_l_n !== 1'b1) begin
            errors++;
            $display("FAIL write_masks: u_n=%b l_n=%b want 0 1", m_u_n, m_l_n);
        end
        wait_done(2, cyc, q, qv, qn, ok);
        checks++;
        if (!ok || c_ack !== 3'b110 || qn != 0) begin
            errors++;
            $display("FAIL write_ack: ok=%0d ack=%b qv_pulses=%0d want ack=110 pulses=0", ok, c_ack, qn);
        end
    endtask

    task automatic test_fairness;
        txn_t t; rd_t r;
        int issued[N]; int gcnt[N]; int grants; int prev_g; int cl;
        logic [N-1:0] eqv;
        lat = 1; grants = 0; prev_g = -100;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            issued[i] = 1;
            issue(i, 1'b0, 23'(i * 256), 16'h0, 1'b0, 1'b0);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (m_req !== last_mreq) begin
                last_mreq = m_req;
                cl = int'(m_a[9:8]);
                checks++;
                if (exp_q.size() == 0 || cl != grants % N || m_a !== exp_q[0].a) begin
                    errors++;
                    $display("FAIL fair_order: grant %0d client %0d a=%h want client %0d",
                             grants, cl, m_a, grants % N);
                end
                if (exp_q.size() != 0) t = exp_q.pop_front();
                checks++;
                if (cyc - prev_g < 2) begin
                    errors++;
                    $display("FAIL fair_spacing: gap %0d want >=2", cyc - prev_g);
                end
                prev_g = cyc;
                if (cl < N) gcnt[cl]++;
                grants++;
            end
            if (c_qv !== '0) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL fair_rdata: qv=%b with nothing expected", c_qv);
                end else begin
                    r = rd_q.pop_front();
                    eqv = '0;
                    eqv[r.cl] = 1'b1;
                    if (c_qv !== eqv || c_q !== r.q) begin
                        errors++;
                        $display("FAIL fair_rdata: qv=%b q=%h want %b %h", c_qv, c_q, eqv, r.q);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (c_ack[i] === c_req[i] && issued[i] < 3) begin
                    issue(i, 1'b0, 23'(i * 256 + issued[i]), 16'h0, 1'b0, 1'b0);
                    issued[i]++;
                end
            end
            if (grants == 9 && c_ack === c_req && rd_q.size() == 0) break;
        end
        checks++;
        if (grants != 9 || gcnt[0] != 3 || gcnt[1] != 3 || gcnt[2] != 3 || c_ack !== c_req) begin
            errors++;
            $display("FAIL fair_counts: total=%0d per=%0d/%0d/%0d want 9 3/3/3",
                     grants, gcnt[0], gcnt[1], gcnt[2]);
        end
    endtask

    task automatic test_hold_busy;
        txn_t t; rd_t r; int cyc; bit ok; int bad; logic [15:0] q; logic [N-1:0] qv; int qn;
        lat = 5; bad = 0; ok = 1'b0; q = '0; qv = '0;
        issue(1, 1'b0, 23'h011111, 16'h0, 1'b0, 1'b0);
        wait_mreq(cyc, ok);
        t = exp_q.pop_front();
        @(negedge clk);
        @(negedge clk);
        issue(0, 1'b0, 23'h022222, 16'h0, 1'b0, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_a !== t.a) bad++;
            if (c_qv !== '0) begin qv = c_qv; q = c_q; end
            if (c_ack[1] === c_req[1]) begin ok = 1'b1; break; end
        end
        r = rd_q.pop_front();
        checks++;
        if (!ok || bad != 0 || qv !== 3'b010 || q !== r.q) begin
            errors++;
            $display("FAIL hold_busy: ok=%0d moved=%0d qv=%b q=%h want 0 010 %h", ok, bad, qv, q, r.q);
        end
        wait_mreq(cyc, ok);
        t = exp_q.pop_front();
        checks++;
        if (!ok || cyc != 1 || m_a !== t.a) begin
            errors++;
            $display("FAIL hold_next_grant: cyc=%0d a=%h want 1 %h", cyc, m_a, t.a);
        end
        wait_done(0, cyc, q, qv, qn, ok);
        r = rd_q.pop_front();
        checks++;
        if (!ok || qv !== 3'b001 || q !== r.q) begin
            errors++;
            $display("FAIL hold_c0_data: qv=%b q=%h want 001 %h", qv, q, r.q);
        end
    endtask

    task automatic test_reset_midop;
        int cyc; bit ok; int bad;
        lat = 8; bad = 0;
        issue(2, 1'b1, 23'h033333, 16'h1234, 1'b0, 1'b0);
        wait_mreq(cyc, ok);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || m_a !== '0 || m_d !== 16'h0 ||
            m_u_n !== 1'b1 || m_l_n !== 1'b1 || c_ack !== 3'b000 || c_qv !== 3'b000 || c_q !== 16'h0) begin
            errors++;
            $display("FAIL reset_midop: req=%b we=%b a=%h d=%h un=%b ln=%b ack=%b q=%h want reset values",
                     m_req, m_we, m_a, m_d, m_u_n, m_l_n, c_ack, c_q);
        end
        c_req = '0;
        exp_q.delete();
        rd_q.delete();
        last_mreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_req !== 1'b0 || c_ack !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_release_idle: %0d cycles with activity want 0", bad);
        end
    endtask

    task automatic test_prio;
        txn_t t; rd_t r; int cyc; bit ok; logic [15:0] q; logic [N-1:0] qv; int qn;
        logic [N-1:0] eqv;
        lat = 2;
        issue(1, 1'b0, 23'h044444, 16'h0, 1'b0, 1'b0);
        wait_mreq(cyc, ok);
        t = exp_q.pop_front();
        wait_done(1, cyc, q, qv, qn, ok);
        r = rd_q.pop_front();
        checks++;
        if (!ok || qv !== 3'b010 || q !== r.q) begin
            errors++;
            $display("FAIL prio_setup: qv=%b q=%h want 010 %h", qv, q, r.q);
        end
`ifdef SDRAM_ARB_PRIO0_EN
        issue(0, 1'b0, 23'h055000, 16'h0, 1'b0, 1'b0);
        issue(2, 1'b0, 23'h066000, 16'h0, 1'b0, 1'b0);
`else
        issue(2, 1'b0, 23'h066000, 16'h0, 1'b0, 1'b0);
        issue(0, 1'b0, 23'h055000, 16'h0, 1'b0, 1'b0);
`endif
        for (int g = 0; g < 2; g++) begin
            wait_mreq(cyc, ok);
            t = exp_q.pop_front();
            checks++;
            if (!ok || m_a !== t.a) begin
                errors++;
                $display("FAIL prio_order: grant %0d a=%h want %h", g, m_a, t.a);
            end
            wait_done(t.cl, cyc, q, qv, qn, ok);
            r = rd_q.pop_front();
            eqv = '0;
            eqv[r.cl] = 1'b1;
            checks++;
            if (!ok || qv !== eqv || q !== r.q) begin
                errors++;
                $display("FAIL prio_data: grant %0d qv=%b q=%h want %b %h", g, qv, q, eqv, r.q);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_fairness();
        test_hold_busy();
        test_reset_midop();
        test_prio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
